// File: rtl/led_activity_monitor.sv
// Status LED driver: a clk_i heartbeat blink plus a stretched, retriggerable
// indicator of JTAG TCK activity, with a wrapping TCK rising-edge counter.
module led_activity_monitor #(
  parameter int CLK_HALF_PERIOD = 25000000,
  parameter int TCK_STRETCH     = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             tck_i,
  output logic             clk_led_o,
  output logic             tck_led_o,
  output logic [CNT_W-1:0] tck_edge_cnt_o
);

  localparam int DIV_W = $clog2(CLK_HALF_PERIOD);
  localparam int STR_W = (TCK_STRETCH > 1) ? $clog2(TCK_STRETCH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF_PERIOD - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(TCK_STRETCH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   clk_led_q, clk_led_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STR_W-1:0]       stretch_q, stretch_d;
  state_e                 state_q, state_d;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tck_i};
    hist_d    = sync_q[SYNC_STAGES-1];
    rise_d    = sync_q[SYNC_STAGES-1] & ~hist_q;
    // The count moves on the same edge that captures the rise pulse for the FSM.
    cnt_d     = cnt_q + CNT_W'(rise_d);
    div_d     = '0;
    clk_led_d = 1'b0;
    if (en_i) begin
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        clk_led_d = ~clk_led_q;
      end else begin
        div_d     = div_q + DIV_W'(1);
        clk_led_d = clk_led_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    if (!en_i) begin
      state_d   = IDLE;
      stretch_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_q) begin
            state_d   = ACTIVE;
            stretch_d = STR_LOAD;
          end
        end
        ACTIVE: begin
          // A fresh TCK edge wins over expiry, keeping the LED lit seamlessly.
          if (rise_q) begin
            stretch_d = STR_LOAD;
          end else if (stretch_q == '0) begin
            state_d = IDLE;
          end else begin
            stretch_d = stretch_q - STR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      rise_q    <= 1'b0;
      div_q     <= '0;
      clk_led_q <= 1'b0;
      cnt_q     <= '0;
      stretch_q <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      rise_q    <= rise_d;
      div_q     <= div_d;
      clk_led_q <= clk_led_d;
      cnt_q     <= cnt_d;
      stretch_q <= stretch_d;
      state_q   <= state_d;
    end
  end

  assign clk_led_o      = clk_led_q;
  assign tck_led_o      = (state_q == ACTIVE);
  assign tck_edge_cnt_o = cnt_q;

endmodule

// File: tb/tb_led_activity_monitor.sv
// Self-checking bench for led_activity_monitor: vector table, directed corner
// sequences and random traffic against an edge-history reference model.
module tb_led_activity_monitor;

  localparam int HALF    = 4;
  localparam int STRETCH = 8;
  localparam int SYNC    = 2;
  localparam int MAXE    = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        tck = 1'b0;
  logic        clk_led, tck_led, clk_led_s, tck_led_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_activity_monitor #(
    .CLK_HALF_PERIOD(HALF), .TCK_STRETCH(STRETCH), .SYNC_STAGES(SYNC), .CNT_W(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tck_i(tck),
    .clk_led_o(clk_led), .tck_led_o(tck_led), .tck_edge_cnt_o(cnt)
  );

  // Narrow-counter copy on the same stimulus, used to observe the wrap quickly.
  led_activity_monitor #(
    .CLK_HALF_PERIOD(HALF), .TCK_STRETCH(STRETCH), .SYNC_STAGES(SYNC), .CNT_W(4)
  ) u_dut_w4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tck_i(tck),
    .clk_led_o(clk_led_s), .tck_led_o(tck_led_s), .tck_edge_cnt_o(cnt_s)
  );

  // Reference model: per-edge history of the sampled inputs.
  bit rst_h  [MAXE];
  bit en_h   [MAXE];
  bit tck_h  [MAXE];
  bit rise_h [MAXE];
  int n_edges  = 0;
  int last_rst = -1;
  int en_run   = 0;
  int cnt_m    = 0;
  bit exp_clk, exp_tled;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n_edges);
    end
  endtask

  function automatic bit hi(input int m);
    return (m >= 0 && m > last_rst) ? tck_h[m] : 1'b0;
  endfunction

  task automatic model_edge();
    int e;
    e = n_edges;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, MAXE);
      $fatal(1);
    end
    rst_h[e] = rst;
    en_h[e]  = en;
    tck_h[e] = tck;
    if (rst) begin
      last_rst  = e;
      rise_h[e] = 1'b0;
      cnt_m     = 0;
      en_run    = 0;
    end else begin
      rise_h[e] = hi(e - SYNC) && !hi(e - SYNC - 1);
      if (rise_h[e]) cnt_m++;
      en_run = en ? en_run + 1 : 0;
    end
    exp_clk  = ((en_run / HALF) % 2) == 1;
    // LED lit iff a rise was taken within the last STRETCH edges with en high and no reset since.
    exp_tled = 1'b0;
    for (int c = e; c >= 0 && c > e - STRETCH; c--) begin
      if (rst_h[c] || !en_h[c]) break;
      if (c >= 1 && rise_h[c-1]) begin
        exp_tled = 1'b1;
        break;
      end
    end
    n_edges++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_clk_led", clk_led, exp_clk);
    check("model_tck_led", tck_led, exp_tled);
    check("model_cnt", cnt, cnt_m & 'hFFFF);
    check("model_cnt_w4", cnt_s, cnt_m & 'hF);
  endtask

  task automatic wait_tck_led(input int bound);
    int n;
    n = 0;
    while (tck_led !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("wait_tck_led", tck_led, 1'b1);
  endtask

  typedef struct packed {
    logic        rst, en, tck, clk_led, tck_led;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, e, t, cl, tl, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.tck = t; v.clk_led = cl; v.tck_led = tl; v.cnt = c;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first_hi, n_hi, base, n;

    // Reset, 20 enabled idle cycles, then one 3-cycle TCK pulse.
    add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 1,0,0);
    add(0,1,0, 1,0,0); add(0,1,0, 1,0,0); add(0,1,0, 1,0,0); add(0,1,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 1,0,0);
    add(0,1,0, 1,0,0); add(0,1,0, 1,0,0); add(0,1,0, 1,0,0); add(0,1,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 1,0,0);
    add(0,1,1, 1,0,0); add(0,1,1, 1,0,0); add(0,1,1, 1,0,1); add(0,1,0, 0,1,1);
    add(0,1,0, 0,1,1); add(0,1,0, 0,1,1); add(0,1,0, 0,1,1); add(0,1,0, 1,1,1);
    add(0,1,0, 1,1,1); add(0,1,0, 1,1,1); add(0,1,0, 1,1,1); add(0,1,0, 0,0,1);
    add(0,1,0, 0,0,1); add(0,1,0, 0,0,1); add(0,1,0, 0,0,1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; tck = vecs[i].tck;
      tick();
      check("vec_clk_led", clk_led, vecs[i].clk_led);
      check("vec_tck_led", tck_led, vecs[i].tck_led);
      check("vec_cnt", cnt, vecs[i].cnt);
    end

    // Retrigger five cycles into ACTIVE keeps the LED lit for 13 cycles.
    base = cnt_m;
    first_hi = -1;
    n_hi = 0;
    for (int i = 0; i < 25; i++) begin
      tck = (i <= 2) || (i >= 5 && i <= 7);
      tick();
      if (tck_led === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = i;
      end
    end
    check("retrig_first_hi", first_hi, 3);
    check("retrig_len", n_hi, 13);
    check("retrig_cnt", cnt, (base + 2) & 'hFFFF);

    // Enable drop mid-ACTIVE and at div_q == 2 while TCK keeps toggling.
    tck = 1'b1; tick(); tick();
    tck = 1'b0;
    wait_tck_led(8);
    en = 1'b0; tick();
    check("en_off_clk_led", clk_led, 1'b0);
    check("en_off_tck_led", tck_led, 1'b0);
    en = 1'b1; tick(); tick();
    en = 1'b0;
    base = cnt_m;
    for (int i = 0; i < 12; i++) begin
      tck = (i % 4) < 2;
      tick();
      check("en_low_clk_led", clk_led, 1'b0);
      check("en_low_tck_led", tck_led, 1'b0);
    end
    check("en_low_cnt", cnt, (base + 3) & 'hFFFF);
    en = 1'b1; tck = 1'b0;
    n = 0;
    while (clk_led !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("reenable_toggle_cycles", n, 4);

    // Counter wrap, seen on the 4-bit instance, counted on the 16-bit one.
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tck = 1'b1; tick(); tick();
      tck = 1'b0; tick(); tick();
      if (i == 15) begin
        check("wrap_w4_allones", cnt_s, 4'hF);
        check("wrap_cnt_15", cnt, 16'd15);
      end
      if (i == 16) begin
        check("wrap_w4_zero", cnt_s, 4'h0);
        check("wrap_cnt_16", cnt, 16'd16);
      end
    end

    // Reset pulse mid-ACTIVE with TCK held high across release.
    tck = 1'b1; tick(); tick();
    tck = 1'b0;
    wait_tck_led(8);
    tck = 1'b1; rst = 1'b1; tick();
    check("rst_clk_led", clk_led, 1'b0);
    check("rst_tck_led", tck_led, 1'b0);
    check("rst_cnt", cnt, 16'd0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("rst_rel_tck_led", tck_led, (i >= 4) ? 1'b1 : 1'b0);
      check("rst_rel_cnt", cnt, (i >= 3) ? 16'd1 : 16'd0);
    end

    // Random traffic: TCK levels held 2..6 cycles, sporadic enable drops and resets.
    n = 0;
    while (n < 3000) begin
      int hold;
      tck  = ~tck;
      hold = $urandom_range(2, 6);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 24) == 0) en = ~en;
        rst = ($urandom_range(0, 299) == 0);
        tick();
        n++;
      end
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
